run_controller: RTL and testbench
=================================

# run_controller

Synthesizable sequencer that owns the processor core's `rst`/`start`/`done` handshake and runs up to `NUM_PROGS` programs back-to-back, one per program slot. For each slot it pulses core reset, raises `start`, counts cycles until `done` or a watchdog timeout, and records cycle count, final PC and status. It sits between the FPGA/bench harness and `top`, replacing hand-written start/wait-done stimulus with a reusable, parametrised on-chip controller.

## Interface
- `PC_W`, 8, core program-counter width
- `NUM_PROGS`, 3, number of program slots (1..16)
- `CNT_W`, 16, cycle-counter width
- `TIMEOUT`, 4096, watchdog limit in cycles; must be < 2^CNT_W
- `RST_CYC`, 2, cycles core reset is held per slot (>=1)
- `clk  in  1  system clock, all logic on rising edge`
- `rst  in  1  synchronous, active-high reset`
- `go  in  1  one-cycle request to start a batch run`
- `prog_mask  in  NUM_PROGS  slots to run; sampled when `go` is accepted`
- `core_done  in  1  core's `done``
- `core_pc  in  PC_W  core's current PC`
- `core_rst  out  1  reset to core (synchronous, active-high)`
- `core_start  out  1  start to core`
- `prog_sel  out  clog2(NUM_PROGS)  active slot index`
- `busy  out  1  batch in progress`
- `batch_done  out  1  one-cycle pulse at batch end`
- `rd_idx  in  clog2(NUM_PROGS)  result read select`
- `rd_cycles  out  CNT_W  cycles recorded for `rd_idx``
- `rd_pc  out  PC_W  final PC recorded for `rd_idx``
- `rd_status  out  2  00 not run, 01 done, 10 timeout`

## Operation
- States: IDLE, CORE_RST, RUN, NEXT, FINISH.
- IDLE: `go`=1 and `prog_mask`!=0 -> latch mask, clear all status to 00, go to NEXT with slot search starting at 0. `go` with mask 0 -> `batch_done` pulse next cycle, stay IDLE. `go` ignored while `busy`.
- NEXT: select lowest set, unvisited mask bit ≥ current index; if found -> CORE_RST with `prog_sel` updated; none left -> FINISH.
- CORE_RST: `core_rst`=1 for exactly `RST_CYC` cycles, `core_start`=0, cycle counter cleared; then RUN.
- RUN: `core_start`=1; counter increments each cycle (saturating at 2^CNT_W−1).
  - `core_done`=1 -> store counter (cycles spent in RUN, inclusive of the done cycle), `core_pc`, status 01; -> NEXT.
  - counter reaches `TIMEOUT` without done -> store `TIMEOUT`, `core_pc`, status 10; -> NEXT.
  - done and timeout in same cycle: done wins (status 01).
- FINISH: `batch_done`=1 for one cycle, `core_start`=0, -> IDLE.
- `core_done` outside RUN is ignored.
- Result readout is combinational from result registers; valid in any state; values persist until next accepted `go` or `rst`.
- `rd_idx` ≥ NUM_PROGS returns zeros.

## Timing
- Reset values: state IDLE, `core_rst`=1 (core held in reset while idle), `core_start`=0, `prog_sel`=0, `busy`=0, `batch_done`=0, all results 0 / status 00.
- `core_rst` is 1 in IDLE, CORE_RST and FINISH; 0 only in RUN and NEXT.
- `busy`=1 from cycle after `go` accepted through FINISH inclusive.
- Latency `go` -> first `core_start`=1: 1 (NEXT) + `RST_CYC` + 1 cycles = 4 at defaults.
- Per-slot overhead between a `core_done` and next slot's `core_start`: 1 + `RST_CYC` cycles.
- `rst` mid-batch: next cycle fully in reset state; partial results discarded; core forced to reset.
- All outputs registered except `rd_*`.

## Structure
- Shared package `run_ctrl_pkg`: state enum, status codes (ST_NONE, ST_DONE, ST_TIMEOUT), default widths.
- One sub-module: `sat_counter` (width param, sync clear, enable, saturating increment, terminal-compare output against `TIMEOUT`).
- Result storage: per-slot register arrays, no RAM.

## Test plan
- Single slot: mask=001, core model asserts done after 10 RUN cycles -> slot0 cycles=10, status 01, `batch_done` pulse; first `core_start` 4 cycles after `go`.
- Sparse mask: mask=101, done after 7 and 12 -> slot0=7/01, slot1=00, slot2=12/01; `prog_sel` sequence 0 then 2.
- Timeout: TIMEOUT=20, core never done -> cycles=20, status 10, `rd_pc` equals PC at timeout cycle, batch proceeds to next slot.
- Done on timeout cycle: done asserted exactly at count 20 -> status 01, cycles=20.
- Reset mid-RUN of slot 1 -> next cycle `busy`=0, `core_rst`=1, all status 00; subsequent `go` runs cleanly.
- `go` with mask=000 -> `batch_done` one cycle later, `busy` never asserts; `go` during busy ignored (mask unchanged).

Source files
------------

// File: rtl/run_ctrl_pkg.sv
// Shared types, status codes and default widths for the run controller.
package run_ctrl_pkg;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_CORE_RST = 3'd1,
    S_RUN      = 3'd2,
    S_NEXT     = 3'd3,
    S_FINISH   = 3'd4
  } state_t;

  localparam logic [1:0] ST_NONE    = 2'b00;
  localparam logic [1:0] ST_DONE    = 2'b01;
  localparam logic [1:0] ST_TIMEOUT = 2'b10;

  localparam int DEF_PC_W      = 8;
  localparam int DEF_NUM_PROGS = 3;
  localparam int DEF_CNT_W     = 16;
  localparam int DEF_TIMEOUT   = 4096;
  localparam int DEF_RST_CYC   = 2;

  // Slot index width; a single-slot build still gets a 1-bit index.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with sync clear. Exposes the value the counter
// will hold after this cycle's increment, and whether that value has hit
// the terminal limit, so the caller can act in the same cycle.
module sat_counter #(
  parameter int W     = 16,
  parameter int LIMIT = 4096
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] cnt_inc,
  output logic         at_limit
);

  logic [W-1:0] cnt;

  // Counter register: clear wins over enable.
  always_ff @(posedge clk) begin
    if (rst || clr) cnt <= '0;
    else if (en)    cnt <= cnt_inc;
  end

  assign cnt_inc  = (cnt == {W{1'b1}}) ? cnt : cnt + 1'b1;
  assign at_limit = (cnt_inc >= W'(LIMIT));

endmodule

// File: rtl/run_controller.sv
// Batch sequencer for the core's rst/start/done handshake.
// Handshake: go is a one-cycle request, accepted only while busy=0; busy
// rises the cycle after acceptance and stays high through the batch_done
// cycle. Readout via rd_idx is valid at any time and holds the last batch.
module run_controller
  import run_ctrl_pkg::*;
#(
  parameter int PC_W      = DEF_PC_W,
  parameter int NUM_PROGS = DEF_NUM_PROGS,
  parameter int CNT_W     = DEF_CNT_W,
  parameter int TIMEOUT   = DEF_TIMEOUT,
  parameter int RST_CYC   = DEF_RST_CYC
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              go,
  input  logic [NUM_PROGS-1:0]              prog_mask,
  input  logic                              core_done,
  input  logic [PC_W-1:0]                   core_pc,
  output logic                              core_rst,
  output logic                              core_start,
  output logic [idx_width(NUM_PROGS)-1:0]   prog_sel,
  output logic                              busy,
  output logic                              batch_done,
  input  logic [idx_width(NUM_PROGS)-1:0]   rd_idx,
  output logic [CNT_W-1:0]                  rd_cycles,
  output logic [PC_W-1:0]                   rd_pc,
  output logic [1:0]                        rd_status
);

  localparam int IDX_W = idx_width(NUM_PROGS);
  localparam int RC_W  = $clog2(RST_CYC + 1);

  state_t               state, state_nx;
  logic [NUM_PROGS-1:0] pending;
  logic [RC_W-1:0]      rc;
  logic                 found;
  logic [IDX_W-1:0]     sel_idx;
  logic [CNT_W-1:0]     cnt_inc;
  logic                 at_limit;
  logic                 go_ok;

  logic [CNT_W-1:0] res_cycles [NUM_PROGS];
  logic [PC_W-1:0]  res_pc     [NUM_PROGS];
  logic [1:0]       res_status [NUM_PROGS];

  assign go_ok = (state == S_IDLE) && go && (prog_mask != '0);

  sat_counter #(.W(CNT_W), .LIMIT(TIMEOUT)) u_cnt (
    .clk      (clk),
    .rst      (rst),
    .clr      (state == S_CORE_RST),
    .en       (state == S_RUN),
    .cnt_inc  (cnt_inc),
    .at_limit (at_limit)
  );

  // Lowest pending slot; visited slots are removed from pending.
  always_comb begin
    found   = 1'b0;
    sel_idx = '0;
    for (int i = NUM_PROGS - 1; i >= 0; i--) begin
      if (pending[i]) begin
        found   = 1'b1;
        sel_idx = IDX_W'(i);
      end
    end
  end

  // Next-state logic.
  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:     if (go_ok) state_nx = S_NEXT;
      S_NEXT:     state_nx = found ? S_CORE_RST : S_FINISH;
      S_CORE_RST: if (rc == RC_W'(RST_CYC - 1)) state_nx = S_RUN;
      S_RUN:      if (core_done || at_limit) state_nx = S_NEXT;
      S_FINISH:   state_nx = S_IDLE;
      default:    state_nx = S_IDLE;
    endcase
  end

  // State, slot bookkeeping and registered outputs decoded from next state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      pending    <= '0;
      rc         <= '0;
      core_rst   <= 1'b1;
      core_start <= 1'b0;
      prog_sel   <= '0;
      busy       <= 1'b0;
      batch_done <= 1'b0;
    end else begin
      state      <= state_nx;
      core_rst   <= (state_nx == S_IDLE) || (state_nx == S_CORE_RST) ||
                    (state_nx == S_FINISH);
      core_start <= (state_nx == S_RUN);
      busy       <= (state_nx != S_IDLE);
      batch_done <= (state_nx == S_FINISH) ||
                    ((state == S_IDLE) && go && (prog_mask == '0));
      if (go_ok) pending <= prog_mask;
      if (state == S_NEXT && found) begin
        prog_sel          <= sel_idx;
        pending[sel_idx]  <= 1'b0;
        rc                <= '0;
      end
      if (state == S_CORE_RST) rc <= rc + 1'b1;
    end
  end

  // Per-slot result registers; done takes priority over timeout.
  always_ff @(posedge clk) begin
    if (rst || go_ok) begin
      for (int i = 0; i < NUM_PROGS; i++) begin
        res_cycles[i] <= '0;
        res_pc[i]     <= '0;
        res_status[i] <= ST_NONE;
      end
    end else if (state == S_RUN) begin
      if (core_done) begin
        res_cycles[prog_sel] <= cnt_inc;
        res_pc[prog_sel]     <= core_pc;
        res_status[prog_sel] <= ST_DONE;
      end else if (at_limit) begin
        res_cycles[prog_sel] <= CNT_W'(TIMEOUT);
        res_pc[prog_sel]     <= core_pc;
        res_status[prog_sel] <= ST_TIMEOUT;
      end
    end
  end

  // Combinational readout; out-of-range indices read as zero.
  always_comb begin
    rd_cycles = '0;
    rd_pc     = '0;
    rd_status = ST_NONE;
    if (int'(rd_idx) < NUM_PROGS) begin
      rd_cycles = res_cycles[rd_idx];
      rd_pc     = res_pc[rd_idx];
      rd_status = res_status[rd_idx];
    end
  end

endmodule

// File: tb/tb_run_controller.sv
// Directed bench for run_controller with a behavioural core model.
module tb_run_controller;

  localparam int TMO   = 20;
  localparam int RES_W = 16 + 8 + 2;

  logic       clk = 1'b0;
  logic       rst;
  logic       go;
  logic [2:0] prog_mask;
  logic       core_done;
  logic [7:0] core_pc;
  logic       core_rst;
  logic       core_start;
  logic [1:0] prog_sel;
  logic       busy;
  logic       batch_done;
  logic [1:0] rd_idx;
  logic [15:0] rd_cycles;
  logic [7:0] rd_pc;
  logic [1:0] rd_status;

  int tests = 0;
  int fails = 0;
  int da [3];
  int run_k = 0;
  logic [RES_W-1:0] exp_q [$];

  run_controller #(.PC_W(8), .NUM_PROGS(3), .CNT_W(16), .TIMEOUT(TMO), .RST_CYC(2)) dut (
    .clk(clk), .rst(rst), .go(go), .prog_mask(prog_mask),
    .core_done(core_done), .core_pc(core_pc),
    .core_rst(core_rst), .core_start(core_start), .prog_sel(prog_sel),
    .busy(busy), .batch_done(batch_done), .rd_idx(rd_idx),
    .rd_cycles(rd_cycles), .rd_pc(rd_pc), .rd_status(rd_status)
  );

  // clock / reset-time watchdog
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  function automatic logic [7:0] pc_of(input int slot, input int k);
    return 8'(slot * 32 + k);
  endfunction

  // Core model: counts RUN cycles, raises done in cycle da[slot] (0 = never).
  always @(negedge clk) begin
    if (core_start) begin
      run_k     = run_k + 1;
      core_done = (da[prog_sel] != 0) && (run_k == da[prog_sel]);
      core_pc   = pc_of(int'(prog_sel), run_k);
    end else begin
      run_k     = 0;
      core_done = 1'b0;
      core_pc   = 8'h00;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [RES_W-1:0] exp_res(input int slot, input int d);
    if (d != 0 && d <= TMO) return {16'(d), pc_of(slot, d), 2'b01};
    return {16'(TMO), pc_of(slot, TMO), 2'b10};
  endfunction

  task automatic check_results();
    logic [RES_W-1:0] e;
    for (int i = 0; i < 3; i++) begin
      rd_idx = 2'(i);
      #1;
      e = exp_q.pop_front();
      check($sformatf("slot%0d_result", i), {rd_cycles, rd_pc, rd_status}, e);
    end
    rd_idx = 2'd3;
    #1;
    check("rd_out_of_range", {rd_cycles, rd_pc, rd_status}, 0);
    rd_idx = 2'd0;
    @(negedge clk);
  endtask

  // Drive one batch; busy_go > 0 pulses a conflicting go at that cycle.
  task automatic run_batch(input logic [2:0] m, input int d0, input int d1,
                           input int d2, input int busy_go);
    int sel_q [$];
    int cyc, first, starts, nexp;
    logic prev, seen;
    da[0] = d0; da[1] = d1; da[2] = d2;
    nexp = 0;
    for (int i = 0; i < 3; i++) begin
      if (m[i]) begin
        sel_q.push_back(i);
        exp_q.push_back(exp_res(i, da[i]));
        nexp++;
      end else begin
        exp_q.push_back('0);
      end
    end
    go = 1'b1;
    prog_mask = m;
    @(negedge clk);
    go = 1'b0;
    cyc = 1; first = -1; starts = 0; prev = 1'b0; seen = 1'b0;
    while (cyc < 400 && !seen) begin
      if (cyc == 1) check("busy_after_go", busy, 1);
      if (cyc == busy_go) begin go = 1'b1; prog_mask = ~m; end
      else go = 1'b0;
      if (core_start && !prev) begin
        starts++;
        if (first < 0) first = cyc;
        if (sel_q.size() > 0) check("prog_sel_order", prog_sel, sel_q.pop_front());
      end
      if (core_start) check("core_rst_in_run", core_rst, 0);
      if (batch_done) seen = 1'b1;
      else begin
        prev = core_start;
        @(negedge clk);
        cyc++;
      end
    end
    go = 1'b0;
    check("batch_done_seen", seen, 1);
    check("go_to_first_start", first, 4);
    check("slots_started", starts, nexp);
    check("busy_in_finish", busy, 1);
    @(negedge clk);
    check("batch_done_width", batch_done, 0);
    check("busy_after_batch", busy, 0);
    check("core_rst_idle", core_rst, 1);
    check_results();
  endtask

  initial begin
    rst = 1'b1; go = 1'b0; prog_mask = 3'b000; rd_idx = 2'd0;
    core_done = 1'b0; core_pc = 8'h00;
    da[0] = 0; da[1] = 0; da[2] = 0;
    repeat (3) @(negedge clk);
    check("rst_core_rst", core_rst, 1);
    check("rst_core_start", core_start, 0);
    check("rst_busy", busy, 0);
    check("rst_batch_done", batch_done, 0);
    check("rst_prog_sel", prog_sel, 0);
    for (int i = 0; i < 3; i++) exp_q.push_back('0);
    rst = 1'b0;
    @(negedge clk);
    check_results();

    // single slot, sparse mask, timeout then next slot, done on timeout cycle
    run_batch(3'b001, 10, 0, 0, 0);
    run_batch(3'b101, 7, 0, 12, 0);
    run_batch(3'b011, 0, 5, 0, 0);
    run_batch(3'b001, 20, 0, 0, 0);

    // empty mask: pulse only, no busy, results untouched
    go = 1'b1; prog_mask = 3'b000;
    @(negedge clk);
    go = 1'b0;
    check("mask0_batch_done", batch_done, 1);
    check("mask0_busy", busy, 0);
    @(negedge clk);
    check("mask0_pulse_end", batch_done, 0);
    check("mask0_busy_later", busy, 0);
    rd_idx = 2'd0;
    #1;
    check("mask0_keeps_results", rd_status, 2'b01);
    @(negedge clk);

    // go while busy must be ignored
    run_batch(3'b001, 15, 4, 4, 3);

    // reset in the middle of slot 1
    da[0] = 3; da[1] = 0; da[2] = 0;
    go = 1'b1; prog_mask = 3'b011;
    @(negedge clk);
    go = 1'b0;
    for (int c = 0; c < 100; c++) begin
      if (prog_sel == 2'd1 && core_start) break;
      @(negedge clk);
    end
    check("slot1_running", core_start, 1);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_busy", busy, 0);
    check("midrst_core_rst", core_rst, 1);
    check("midrst_core_start", core_start, 0);
    check("midrst_prog_sel", prog_sel, 0);
    for (int i = 0; i < 3; i++) begin
      rd_idx = 2'(i);
      #1;
      check($sformatf("midrst_status%0d", i), rd_status, 2'b00);
    end
    rd_idx = 2'd0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    run_batch(3'b010, 0, 6, 0, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
